mcp4725_target: RTL and testbench

MCP4725_TARGET -- requirements
Module: mcp4725_target

---
 rtl/mcp4725_target.sv | 188 ++++++++++++++++++
 tb/tb_mcp4725_target.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mcp4725_target.sv
// I2C target emulating the MCP4725 12-bit DAC register interface.
// SCL/SDA are oversampled by clk; SDA is open-drain and is only ever pulled low.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | bus free or waiting for a fresh START
// ADDR     | shifting in the address byte
// ADDR_ACK | driving ACK for a matched address
// WR_BYTE  | shifting in a write data byte
// WR_ACK   | driving ACK for a write byte
// RD_BYTE  | shifting out a read byte
// RD_ACK   | releasing SDA, sampling initiator ACK/NACK
// IGNORE   | not addressed (or NACKed); wait for START/STOP
module mcp4725_target (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic        A0,
    output logic [11:0] data_reg,
    output logic [1:0]  mode_reg,
    output logic        update,
    output logic        memWrite,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t      state, state_next;
    logic        scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  shift_reg, byte0, byte1, rd_shift, rd_byte;
    logic [3:0]  bit_cnt;
    logic [1:0]  byte_idx, byte_idx_next, rd_idx;
    logic [11:0] snap_data, data_next;
    logic [1:0]  snap_mode, mode_next;
    logic        sda_oe, sda_oe_next;
    logic        byte_done, addr_match, cmd_done, cmd_mem;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    // Synchronizers reset to the idle-bus level so reset release creates no edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_d} <= {SCL, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_d} <= {SDA, sda_s1, sda_s2};
        end
    end

    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_det  = scl_s2 & scl_d & ~sda_s2 & sda_d;
    assign stop_det   = scl_s2 & scl_d & sda_s2 & ~sda_d;
    assign byte_done  = scl_fall && (bit_cnt == 4'd8);
    assign addr_match = (shift_reg[7:1] == {6'b110000, A0});

    always_comb begin
        case (rd_idx)
            2'd0:    rd_byte = {3'b110, 2'b00, snap_mode, 1'b0};
            2'd1:    rd_byte = snap_data[11:4];
            2'd2:    rd_byte = {snap_data[3:0], 4'h0};
            default: rd_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next    = state;
        sda_oe_next   = 1'b0;
        cmd_done      = 1'b0;
        cmd_mem       = 1'b0;
        data_next     = data_reg;
        mode_next     = mode_reg;
        byte_idx_next = byte_idx;
        if (stop_det) begin
            state_next    = IDLE;
            byte_idx_next = 2'd0;
        end else if (start_det) begin
            state_next    = ADDR;
            byte_idx_next = 2'd0;
        end else begin
            case (state)
                ADDR:     if (byte_done) state_next = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall) state_next = shift_reg[0] ? RD_BYTE : WR_BYTE;
                WR_BYTE: begin
                    if (byte_done) begin
                        state_next    = WR_ACK;
                        byte_idx_next = (byte_idx == 2'd3) ? 2'd3 : byte_idx + 2'd1;
                        if (byte_idx == 2'd1 && byte0[7:6] == 2'b00) begin
                            cmd_done  = 1'b1;
                            data_next = {byte0[3:0], shift_reg};
                            mode_next = byte0[5:4];
                        end
                        if (byte_idx == 2'd2 && byte0[7:6] == 2'b01) begin
                            cmd_done  = 1'b1;
                            data_next = {byte1, shift_reg[7:4]};
                            mode_next = byte0[2:1];
                            cmd_mem   = byte0[5];
                        end
                        if (cmd_done) byte_idx_next = 2'd0;
                    end
                end
                WR_ACK:   if (scl_fall) state_next = WR_BYTE;
                RD_BYTE:  if (byte_done) state_next = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s2) state_next = IGNORE;
                    else if (scl_fall)      state_next = RD_BYTE;
                end
                default: ;
            endcase
        end
        // Read data is presented on SCL low: first bit on entry, next bit each fall.
        case (state_next)
            ADDR_ACK, WR_ACK: sda_oe_next = 1'b1;
            RD_BYTE: begin
                if (state != RD_BYTE) sda_oe_next = ~rd_byte[7];
                else if (scl_fall)    sda_oe_next = ~rd_shift[6];
                else                  sda_oe_next = sda_oe;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sda_oe    <= 1'b0;
            shift_reg <= 8'h00;
            bit_cnt   <= 4'd0;
            byte_idx  <= 2'd0;
            byte0     <= 8'h00;
            byte1     <= 8'h00;
            rd_shift  <= 8'h00;
            rd_idx    <= 2'd0;
            snap_data <= 12'h000;
            snap_mode <= 2'b00;
            data_reg  <= 12'h000;
            mode_reg  <= 2'b00;
            update    <= 1'b0;
            memWrite  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            update   <= 1'b0;
            memWrite <= 1'b0;
            sda_oe   <= sda_oe_next;
            byte_idx <= byte_idx_next;
            if (scl_rise && (state == ADDR || state == WR_BYTE))
                shift_reg <= {shift_reg[6:0], sda_s2};
            if (start_det || stop_det || state_next != state)
                bit_cnt <= 4'd0;
            else if (scl_rise && bit_cnt != 4'd8)
                bit_cnt <= bit_cnt + 4'd1;
            if (state == WR_BYTE && state_next == WR_ACK) begin
                if (byte_idx == 2'd0) byte0 <= shift_reg;
                if (byte_idx == 2'd1) byte1 <= shift_reg;
            end
            if (cmd_done) begin
                data_reg <= data_next;
                mode_reg <= mode_next;
                update   <= 1'b1;
                memWrite <= cmd_mem;
            end
            if (state == ADDR && state_next == ADDR_ACK) begin
                busy      <= 1'b1;
                snap_data <= data_reg;
                snap_mode <= mode_reg;
                rd_idx    <= 2'd0;
            end
            if (stop_det || (state == ADDR && state_next == IGNORE))
                busy <= 1'b0;
            if (state_next == RD_BYTE && state != RD_BYTE) begin
                rd_shift <= rd_byte;
                rd_idx   <= (rd_idx == 2'd3) ? 2'd3 : rd_idx + 2'd1;
            end else if (state == RD_BYTE && scl_fall) begin
                rd_shift <= {rd_shift[6:0], 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_mcp4725_target.sv
// Bench for mcp4725_target: bit-banged I2C initiator with an expected-response queue.
`timescale 1ns/1ps
module tb_mcp4725_target;
    localparam int Q = 100;

    logic        clk = 1'b0, rst = 1'b1, scl = 1'b1, a0 = 1'b0, m_low = 1'b0;
    wire         sda_bus;
    logic [11:0] data_reg;
    logic [1:0]  mode_reg;
    logic        update, memwrite, busy;
    int          n_checks = 0, n_err = 0, upd_cnt = 0, mem_cnt = 0, sda_low_cnt = 0;
    int          u0, m0;
    logic        busy_seen = 1'b0, watch_sda = 1'b0;
    logic [31:0] sb_q[$];
    logic [7:0]  rb;
    logic        ab;

    always #5 clk = ~clk;
    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    mcp4725_target dut (
        .clk(clk), .rst(rst), .SCL(scl), .SDA(sda_bus), .A0(a0),
        .data_reg(data_reg), .mode_reg(mode_reg), .update(update),
        .memWrite(memwrite), .busy(busy)
    );

    always @(negedge clk) begin
        if (update)   upd_cnt++;
        if (memwrite) mem_cnt++;
        if (busy)     busy_seen = 1'b1;
        if (watch_sda && !m_low && sda_bus === 1'b0) sda_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop_check(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = 32'hDEAD_BEEF;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        check(tag, got, e);
    endtask

    task automatic bit_out(input logic b);
        m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic bit_in(output logic b);
        m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start;
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(4*Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic ack_exp);
        logic a;
        sb_q.push_back({31'd0, ack_exp});
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(a);
        sb_pop_check("ack", {31'd0, a});
    endtask

    task automatic rd_byte(output logic [7:0] b, input logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            bit_in(x);
            b[i] = x;
        end
        bit_out(ack);
    endtask

    task automatic fast_write(input logic [7:0] b0, input logic [7:0] b1);
        i2c_start; wr_byte(8'hC0, 1'b0); wr_byte(b0, 1'b0); wr_byte(b1, 1'b0); i2c_stop;
    endtask

    initial begin
        #20 rst = 1'b0;
        #(3*Q);
        check("rst_data", data_reg, 32'h0);
        check("rst_mode", mode_reg, 32'h0);
        check("rst_update", update, 32'h0);
        check("rst_memwrite", memwrite, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_sda", sda_bus, 32'h1);
        rst = 1'b1; #(2*Q);

        // Fast write with A0=1
        a0 = 1'b1; u0 = upd_cnt; m0 = mem_cnt;
        i2c_start; wr_byte(8'hC2, 1'b0);
        check("busy_on", busy, 32'h1);
        wr_byte(8'h2A, 1'b0); wr_byte(8'hBC, 1'b0); i2c_stop;
        check("fast_data", data_reg, 32'hABC);
        check("fast_mode", mode_reg, 32'h2);
        check("fast_upd", upd_cnt - u0, 32'd1);
        check("fast_mem", mem_cnt - m0, 32'd0);
        check("busy_off", busy, 32'h0);

        // Write DAC + EEPROM
        a0 = 1'b0; u0 = upd_cnt; m0 = mem_cnt;
        i2c_start; wr_byte(8'hC0, 1'b0); wr_byte(8'h60, 1'b0); wr_byte(8'h12, 1'b0);
        wr_byte(8'h30, 1'b0); i2c_stop;
        check("eep_data", data_reg, 32'h123);
        check("eep_mode", mode_reg, 32'h0);
        check("eep_upd", upd_cnt - u0, 32'd1);
        check("eep_mem", mem_cnt - m0, 32'd1);

        // Address mismatch
        sda_low_cnt = 0; busy_seen = 1'b0; watch_sda = 1'b1; u0 = upd_cnt;
        i2c_start; wr_byte(8'hC2, 1'b1); wr_byte(8'h55, 1'b1); i2c_stop;
        watch_sda = 1'b0;
        check("nomatch_sda", sda_low_cnt, 32'd0);
        check("nomatch_busy", {31'd0, busy_seen}, 32'd0);
        check("nomatch_data", data_reg, 32'h123);
        check("nomatch_upd", upd_cnt - u0, 32'd0);

        // Read back with PD=01
        fast_write(8'h11, 8'h23);
        check("pd_data", data_reg, 32'h123);
        check("pd_mode", mode_reg, 32'h1);
        i2c_start; wr_byte(8'hC1, 1'b0);
        sb_q.push_back(32'hC2); sb_q.push_back(32'h12); sb_q.push_back(32'h30);
        rd_byte(rb, 1'b0); sb_pop_check("rd0", {24'd0, rb});
        rd_byte(rb, 1'b0); sb_pop_check("rd1", {24'd0, rb});
        rd_byte(rb, 1'b1); sb_pop_check("rd2", {24'd0, rb});
        bit_in(ab);
        check("rd_release", ab, 32'h1);
        i2c_stop;

        i2c_start; wr_byte(8'hC1, 1'b0);
        sb_q.push_back(32'hC2); sb_q.push_back(32'h12); sb_q.push_back(32'h30);
        sb_q.push_back(32'hFF); sb_q.push_back(32'hFF);
        for (int i = 0; i < 5; i++) begin
            rd_byte(rb, (i == 4));
            sb_pop_check("rd_long", {24'd0, rb});
        end
        i2c_stop;

        // Fast write boundary and partial command
        fast_write(8'h0F, 8'h00);
        check("f00_data", data_reg, 32'hF00);
        check("f00_mode", mode_reg, 32'h0);
        u0 = upd_cnt;
        i2c_start; wr_byte(8'hC0, 1'b0); wr_byte(8'h05, 1'b0); i2c_stop;
        check("partial_data", data_reg, 32'hF00);
        check("partial_upd", upd_cnt - u0, 32'd0);

        // Back-to-back fast writes in one transfer
        u0 = upd_cnt;
        i2c_start; wr_byte(8'hC0, 1'b0); wr_byte(8'h01, 1'b0); wr_byte(8'h11, 1'b0);
        wr_byte(8'h02, 1'b0); wr_byte(8'h22, 1'b0); i2c_stop;
        check("multi_data", data_reg, 32'h222);
        check("multi_upd", upd_cnt - u0, 32'd2);

        // Reserved command: ACKed, ignored
        u0 = upd_cnt; m0 = mem_cnt;
        i2c_start; wr_byte(8'hC0, 1'b0); wr_byte(8'hE0, 1'b0); wr_byte(8'h11, 1'b0);
        wr_byte(8'h22, 1'b0); i2c_stop;
        check("rsvd_data", data_reg, 32'h222);
        check("rsvd_pulses", (upd_cnt - u0) + (mem_cnt - m0), 32'd0);

        // Reset while the target holds SDA low
        i2c_start; wr_byte(8'hC0, 1'b0);
        for (int i = 7; i >= 0; i--) bit_out(i == 3 || i == 1);
        m_low = 1'b0; #1;
        check("ack_drv", sda_bus, 32'h0);
        rst = 1'b0; #1;
        check("rstmid_sda", sda_bus, 32'h1);
        check("rstmid_data", data_reg, 32'h0);
        check("rstmid_mode", mode_reg, 32'h0);
        check("rstmid_busy", busy, 32'h0);
        #Q; scl = 1'b1; #Q; rst = 1'b1; #(2*Q);
        u0 = upd_cnt;
        fast_write(8'h0A, 8'hBC);
        check("post_rst_data", data_reg, 32'hABC);
        check("post_rst_upd", upd_cnt - u0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
